sample_fifo: RTL and testbench
==============================

SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, same as the upstream register stage output.
REQ-002 Parameter DEPTH, default 4: number of stored words; power of two, at least 2.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_d  input  WIDTH  write data, taken from the upstream register stage output o_q.
REQ-006 i_valid  input  1  write request; i_d is valid this cycle.
REQ-007 o_ready  output  1  FIFO can accept a write this cycle.
REQ-008 o_q  output  WIDTH  head-of-FIFO data.
REQ-009 o_valid  output  1  o_q holds a valid word.
REQ-010 i_ready  input  1  downstream consumer accepts o_q this cycle.
REQ-011 o_count  output  $clog2(DEPTH)+1  number of words currently stored.
REQ-012 o_overflow  output  1  sticky flag: a write was attempted while full.
REQ-013 i_clr_ovf  input  1  synchronous clear of o_overflow.

Function
REQ-014 The FIFO SHALL push i_d when i_valid && o_ready, and pop the head word when o_valid && i_ready.
REQ-015 o_ready SHALL be 1 exactly when o_count < DEPTH. This is combinational from state only, with no dependence on i_ready.
REQ-016 o_valid SHALL be 1 exactly when o_count != 0.
REQ-017 The FIFO SHALL be first-word fall-through: o_q SHALL equal the oldest stored word combinationally whenever o_valid=1, and SHALL be 0 whenever o_valid=0.
REQ-018 Write-to-read latency SHALL be 1 cycle: a word pushed into an empty FIFO at edge N SHALL appear on o_q with o_valid=1 after edge N.
REQ-019 The write and read pointers SHALL each be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-020 Count update per edge:
  - push only: +1
  - pop only: -1
  - simultaneous push and pop: unchanged, both pointers advance.
REQ-021 When full, a push together with a pop SHALL NOT occur, because o_ready=0. Only the pop takes effect, and o_count becomes DEPTH-1.
REQ-022 When empty, an asserted i_ready SHALL be ignored, with no pointer movement and no underflow.
REQ-023 The FIFO SHALL preserve word order exactly; no word is dropped or duplicated except a rejected write.
REQ-024 A rejected write (i_valid=1 while o_ready=0) SHALL NOT modify storage, pointers or count, and SHALL set o_overflow at that edge.
REQ-025 o_overflow SHALL stay set until a rising edge with i_clr_ovf=1. If a rejected write and i_clr_ovf coincide, o_overflow SHALL remain 1 (set wins).
REQ-026 Storage contents SHALL NOT be required to be reset. Outputs SHALL never expose unwritten storage, per REQ-017.

Reset
REQ-027 i_rst_n=0 SHALL immediately, without a clock edge, force:
  - pointers=0, o_count=0
  - o_valid=0, o_q=0, o_ready=1
  - o_overflow=0
REQ-028 Reset asserted mid-operation SHALL discard all stored words. After i_rst_n returns to 1, the first rising edge SHALL behave as from an empty FIFO.
REQ-029 Inputs SHALL be ignored while i_rst_n=0.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset then idle: hold i_rst_n=0, then release -> o_count=0, o_valid=0, o_q=8'h00, o_ready=1, o_overflow=0.
REQ-031 Single pass-through: push 8'hA5 with i_ready=0 -> next cycle o_valid=1, o_q=8'hA5, o_count=1. Then i_ready=1 for one cycle -> o_valid=0, o_q=8'h00, o_count=0.
REQ-032 Fill and overflow: push 8'h01..8'h04 -> o_count=4, o_ready=0. Attempt push 8'h05 -> o_overflow=1 and contents unchanged. Drain -> outputs 01,02,03,04 in order.
REQ-033 Wrap-around with concurrency: keep o_count=2 while pushing and popping every cycle for 10 cycles with data 8'h10..8'h19 -> output sequence is contiguous and in order, o_count stays 2.
REQ-034 Overflow clear priority: with the FIFO full, assert i_valid=1 and i_clr_ovf=1 together -> o_overflow=1. Next cycle, i_valid=0 and i_clr_ovf=1 -> o_overflow=0.
REQ-035 Async reset mid-stream: with o_count=3, pull i_rst_n low between clock edges -> o_valid=0 and o_count=0 before the next edge. Push 8'h77 after release -> o_q=8'h77.

Source files
------------

// File: rtl/sample_fifo.sv
// First-word fall-through sample FIFO with a sticky overflow flag.
// Head data is visible combinationally; empty reads return zero.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [WIDTH-1:0]           i_d,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [WIDTH-1:0]           o_q,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    input  logic                       i_clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             ovf_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             reject_s;

    // Handshake decode from stored state only.
    always_comb begin
        full_s   = (count_r == CW'(DEPTH));
        empty_s  = (count_r == {CW{1'b0}});
        push_s   = i_valid && !full_s;
        pop_s    = i_ready && !empty_s;
        reject_s = i_valid && full_s;
    end

    // Storage write; contents are never exposed until written.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_d;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a rejected write outranks a clear on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_r <= 1'b0;
        end else if (reject_s) begin
            ovf_r <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Output mapping from registered state.
    always_comb begin
        o_ready    = !full_s;
        o_valid    = !empty_s;
        o_count    = count_r;
        o_overflow = ovf_r;
        if (empty_s) begin
            o_q = {WIDTH{1'b0}};
        end else begin
            o_q = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo with a queue-based reference model
// checked every falling edge plus hand-computed expectations.
module tb_sample_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] q;
    logic             valid_out;
    logic             ready_in;
    logic [2:0]       count;
    logic             overflow;
    logic             clr_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] mq[$];
    logic             movf;

    sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_d        (d),
        .i_valid    (valid_in),
        .o_ready    (ready_out),
        .o_q        (q),
        .o_valid    (valid_out),
        .i_ready    (ready_in),
        .o_count    (count),
        .o_overflow (overflow),
        .i_clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Compare DUT against the reference model away from the active edge.
    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_valid", 32'(valid_out), 32'(mq.size() != 0));
        chk("m_ready", 32'(ready_out), 32'(mq.size() < DEPTH));
        chk("m_q", 32'(q), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("m_ovf", 32'(overflow), 32'(movf));
    end

    // Drive one cycle of inputs and advance the model by the FIFO rules.
    task automatic cyc(input logic v, input logic [7:0] dv, input logic r, input logic c);
        logic do_push;
        logic do_pop;
        valid_in = v;
        d        = dv;
        ready_in = r;
        clr_ovf  = c;
        @(posedge clk);
        do_push = v && (mq.size() < DEPTH);
        do_pop  = r && (mq.size() != 0);
        if (v && mq.size() == DEPTH) movf = 1'b1;
        else if (c) movf = 1'b0;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(dv);
        @(negedge clk);
        valid_in = 1'b0;
        d        = 8'h00;
        ready_in = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        d        = 8'h00;
        ready_in = 1'b0;
        clr_ovf  = 1'b0;
        movf     = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);

        // Single pass-through
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("pt_valid", 32'(valid_out), 32'd1);
        chk("pt_q", 32'(q), 32'hA5);
        chk("pt_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pt_valid0", 32'(valid_out), 32'd0);
        chk("pt_q0", 32'(q), 32'h00);
        chk("pt_count0", 32'(count), 32'd0);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(ready_out), 32'd0);
        cyc(1'b1, 8'h05, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_q", 32'(q), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_count", 32'(count), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Wrap-around with concurrent push/pop at depth 2
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("wrap_q", 32'(q), 32'(8'h10 + k));
            cyc(1'b1, 8'(8'h12 + k), 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 32'd2);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow clear priority, then full push+pop
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h24, 1'b0, 1'b1);
        chk("prio_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("prio_clr", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h25, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count), 32'd3);
        chk("fullpp_q", 32'(q), 32'h21);

        // Async reset mid-stream, inputs ignored while held
        #2 rst_n = 1'b0;
        mq.delete();
        movf = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_q", 32'(q), 32'h00);
        chk("arst_ready", 32'(ready_out), 32'd1);
        chk("arst_ovf", 32'(overflow), 32'd0);
        valid_in = 1'b1;
        d        = 8'h99;
        @(negedge clk);
        valid_in = 1'b0;
        d        = 8'h00;
        chk("arst_hold_count", 32'(count), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_q", 32'(q), 32'h77);
        chk("post_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
